// File: rtl/avl_timer_slave.sv
// avl_timer_slave: Avalon-MM wait-stated slave with a prescaled 32-bit down-counting interval timer and level irq
module avl_timer_slave #(
  parameter int WAIT_CYCLES = 1,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] avl_address,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic [3:0]  avl_byteenable,
  output logic [31:0] avl_readdata,
  output logic        avl_waitrequest,
  output logic        avl_irq
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  state_t state, state_n;
  logic [3:0] wcnt, wcnt_n;
  logic [1:0] addr_q;
  logic wr_q, req, enter_ack, commit, ctrl_wr, status_wr, load_wr, count_wr, tick, expire;
  logic [2:0] ctrl, ctrl_n;
  logic expired, expired_n;
  logic [31:0] load, load_n, count, count_n, rd_mux;
  logic [15:0] pre, pre_n;
  logic unused_addr;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    merge = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction
  assign unused_addr = ^{avl_address[31:4], avl_address[1:0]};
  assign req = avl_read | avl_write;
  assign avl_waitrequest = rst || state != ACK;
  // Transfer sequencing: the request cycle is the first wait cycle; dropping the request in WAIT aborts
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    case (state)
      IDLE: if (req) begin
        wcnt_n = WAIT_INIT;
        state_n = (WAIT_INIT == 4'd0) ? ACK : WAIT;
      end
      WAIT: if (!req) state_n = IDLE;
        else begin
          wcnt_n = wcnt - 4'd1;
          state_n = (wcnt == 4'd1) ? ACK : WAIT;
        end
      default: state_n = IDLE;
    endcase
  end
  // Register decode, read mux and timer next-state; bus writes to COUNT and CTRL take priority over the timer
  always_comb begin
    enter_ack = state != ACK && state_n == ACK;
    commit = state == ACK && wr_q;
    ctrl_wr = commit && addr_q == 2'd0;
    status_wr = commit && addr_q == 2'd1;
    load_wr = commit && addr_q == 2'd2;
    count_wr = commit && addr_q == 2'd3;
    rd_mux = avl_address[3:2] == 2'd0 ? {29'd0, ctrl} :
             avl_address[3:2] == 2'd1 ? {31'd0, expired} :
             avl_address[3:2] == 2'd2 ? load : count;
    tick = ctrl[0] && pre == PRE_MAX;
    expire = tick && count == 32'd0;
    pre_n = (!ctrl[0] || ctrl_wr || tick) ? 16'd0 : pre + 16'd1;
    ctrl_n = (ctrl_wr && avl_byteenable[0]) ? avl_writedata[2:0] :
             (expire && !ctrl[2]) ? {ctrl[2:1], 1'b0} : ctrl;
    expired_n = expire || (expired && !(status_wr && avl_byteenable[0] && avl_writedata[0]));
    load_n = load_wr ? merge(load, avl_writedata, avl_byteenable) : load;
    count_n = count_wr ? merge(count, avl_writedata, avl_byteenable) :
              !tick ? count :
              count != 32'd0 ? count - 32'd1 :
              ctrl[2] ? load : count;
  end
  // Bus-side state: FSM, wait counter, and address/direction/readdata captured on ACK entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= 4'd0;
      addr_q <= 2'd0;
      wr_q <= 1'b0;
      avl_readdata <= 32'd0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      if (enter_ack) begin
        addr_q <= avl_address[3:2];
        wr_q <= avl_write;
        avl_readdata <= avl_write ? 32'd0 : rd_mux;
      end
    end
  end
  // Timer registers; irq is registered from the next register state so it tracks STATUS/CTRL without lag
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= 3'd0;
      expired <= 1'b0;
      load <= 32'd0;
      count <= 32'd0;
      pre <= 16'd0;
      avl_irq <= 1'b0;
    end else begin
      ctrl <= ctrl_n;
      expired <= expired_n;
      load <= load_n;
      count <= count_n;
      pre <= pre_n;
      avl_irq <= expired_n && ctrl_n[1];
    end
  end
endmodule

// File: tb/tb_avl_timer_slave.sv
// tb_avl_timer_slave: two timer instances (WAIT 1/PRESCALE 4 and WAIT 3/PRESCALE 1) checked by vector table and timed sequences
module tb_avl_timer_slave;
  typedef struct {
    int d;
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] be;
    logic ck;
    logic [31:0] exp;
  } vec_t;
  logic clk, rst;
  logic read [2];
  logic write [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0] ben [2];
  logic wreq [2];
  logic irq [2];
  logic [31:0] sb [$];
  vec_t tbl [$];
  int n_chk = 0;
  int n_fail = 0;

  avl_timer_slave #(.WAIT_CYCLES(1), .PRESCALE(4)) dut0 (
    .clk(clk), .rst(rst), .avl_address(addr[0]), .avl_read(read[0]), .avl_write(write[0]),
    .avl_writedata(wdata[0]), .avl_byteenable(ben[0]), .avl_readdata(rdata[0]),
    .avl_waitrequest(wreq[0]), .avl_irq(irq[0]));
  avl_timer_slave #(.WAIT_CYCLES(3), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .avl_address(addr[1]), .avl_read(read[1]), .avl_write(write[1]),
    .avl_writedata(wdata[1]), .avl_byteenable(ben[1]), .avl_readdata(rdata[1]),
    .avl_waitrequest(wreq[1]), .avl_irq(irq[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Called at a negedge; returns at the negedge after the edge that leaves ACK (where writes commit)
  task automatic xfer(input int d, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input logic ck, input logic [31:0] exp);
    int lat;
    if (ck) sb.push_back(exp);
    addr[d] = a;
    wdata[d] = wd;
    ben[d] = be;
    read[d] = rd;
    write[d] = wr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (wreq[d] && lat < 40);
    check("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd3);
    if (ck) check("readdata", rdata[d], sb.pop_front());
    @(negedge clk);
    check("ack_one_cycle", 32'(wreq[d]), 32'd1);
    read[d] = 0;
    write[d] = 0;
  endtask

  initial begin
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      read[d] = 1;
      write[d] = 0;
      addr[d] = 0;
      wdata[d] = 0;
      ben[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_waitreq", 32'(wreq[d]), 32'd1);
      check("rst_irq", 32'(irq[d]), 32'd0);
      check("rst_readdata", rdata[d], 32'd0);
    end
    rst = 0;
    read[0] = 0;
    read[1] = 0;

    tbl.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{1, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 4'b0101, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h00AD00EF});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h8, 32'h12345678, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'hFFFFFFF8, 32'h0, 4'h0, 1'b1, 32'h12345678});
    tbl.push_back('{0, 1'b0, 1'b1, 32'hFFFFFFF8, 32'hAABBCCDD, 4'b1010, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'hAA34CC78});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF8, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b1, 32'h0, 32'h1, 4'hF, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h1});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h1});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h4, 32'h1, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h0});
    foreach (tbl[i])
      xfer(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].ck, tbl[i].exp);
    check("table_irq0", 32'(irq[0]), 32'd0);

    addr[1] = 32'h8;
    wdata[1] = 32'h11111111;
    ben[1] = 4'hF;
    write[1] = 1;
    @(negedge clk);
    check("abort_waitreq", 32'(wreq[1]), 32'd1);
    write[1] = 0;
    repeat (4) @(negedge clk);
    check("abort_idle", 32'(wreq[1]), 32'd1);
    xfer(1, 1, 0, 32'h8, 0, 0, 1, 32'h00AD00EF);

    xfer(1, 0, 1, 32'h8, 32'd3, 4'hF, 0, 0);
    xfer(1, 0, 1, 32'hC, 32'd3, 4'hF, 0, 0);
    xfer(1, 0, 1, 32'h0, 32'h7, 4'hF, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("auto_first_expiry", 32'(irq[1]), 32'(k == 4));
    end
    xfer(1, 0, 1, 32'h4, 32'h1, 4'hF, 0, 0);
    check("w1c_vs_expiry_irq", 32'(irq[1]), 32'd1);
    @(negedge clk);
    xfer(1, 0, 1, 32'h4, 32'h1, 4'hF, 0, 0);
    check("w1c_irq_clear", 32'(irq[1]), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("auto_period", 32'(irq[1]), 32'(k == 3));
    end
    xfer(1, 0, 1, 32'hC, 32'h10, 4'hF, 0, 0);
    xfer(1, 1, 0, 32'hC, 0, 0, 1, 32'h0E);
    xfer(1, 0, 1, 32'h0, 32'h0, 4'hF, 0, 0);

    xfer(0, 0, 1, 32'hC, 32'd2, 4'hF, 0, 0);
    xfer(0, 0, 1, 32'h0, 32'h3, 4'hF, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("oneshot_expiry", 32'(irq[0]), 32'(k == 12));
    end
    xfer(0, 1, 0, 32'h0, 0, 0, 1, 32'h2);
    xfer(0, 1, 0, 32'hC, 0, 0, 1, 32'h0);
    repeat (8) @(negedge clk);
    check("oneshot_irq_held", 32'(irq[0]), 32'd1);
    xfer(0, 1, 0, 32'hC, 0, 0, 1, 32'h0);
    xfer(0, 0, 1, 32'h4, 32'h1, 4'hF, 0, 0);
    check("oneshot_w1c", 32'(irq[0]), 32'd0);

    addr[1] = 32'h8;
    wdata[1] = 32'hFFFFFFFF;
    ben[1] = 4'hF;
    write[1] = 1;
    @(negedge clk);
    rst = 1;
    write[1] = 0;
    @(negedge clk);
    check("rst_mid_waitreq", 32'(wreq[1]), 32'd1);
    @(negedge clk);
    rst = 0;
    for (int r = 0; r < 4; r++) xfer(1, 1, 0, 32'(r * 4), 0, 0, 1, 32'h0);
    check("rst_mid_irq", 32'(irq[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
